// File: rtl/unpack_sched_pkg.sv
// Shared types and constants for the unpack scheduler.
// The optional classification outputs are enabled by UNPACK_SCHED_CLASSIFY_EN.
package unpack_sched_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        A0   = 3'd1,
        A1   = 3'd2,
        B0   = 3'd3,
        B1   = 3'd4,
        DONE = 3'd5
    } sched_state_t;

    // One decoded operand, as produced by the shared unpacker.
    typedef struct packed {
        logic        s;
        logic [10:0] e;
        logic [52:0] f;
        logic [5:0]  lz;
        logic [51:0] h;
        logic        fz;
        logic        ez;
        logic        einf;
    } unpacked_t;

    // A single-precision operand is left-justified into the 64-bit unpacker input.
    localparam int F32_PAD = 32;

    // Bit positions inside the one-hot class vector {nan, inf, zero, sub}.
    localparam int CLS_W    = 4;
    localparam int CLS_NAN  = 3;
    localparam int CLS_INF  = 2;
    localparam int CLS_ZERO = 1;
    localparam int CLS_SUB  = 0;

    // Place an operand on the unpacker input according to its precision.
    function automatic logic [63:0] fmt_operand(input logic [63:0] op, input logic db);
        return db ? op : {op[31:0], {F32_PAD{1'b0}}};
    endfunction

    // One-hot class from the first-pass unpacker flags.
    function automatic logic [CLS_W-1:0] classify(input logic einf, input logic fz,
                                                  input logic ez);
        logic [CLS_W-1:0] c;
        c           = '0;
        c[CLS_NAN]  = einf && !fz;
        c[CLS_INF]  = einf && fz;
        c[CLS_ZERO] = ez && fz;
        c[CLS_SUB]  = ez && !fz;
        return c;
    endfunction

endpackage

// File: rtl/unpack_capture.sv
// Holding register for one unpacked operand, with synchronous load and clear.
module unpack_capture
    import unpack_sched_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      clr,
    input  logic      load,
    input  unpacked_t d,
    output unpacked_t q
);

    // Clear wins over load so a new operation never starts from stale fields.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/unpack_sched.sv
// Time-multiplexes one unpacker over both operands of an FPU operation.
// Optional feature macro: UNPACK_SCHED_CLASSIFY_EN adds a_cls, b_cls, out_special.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready are
// both high. in_ready is high only in IDLE outside reset; out_valid is high only
// in DONE and, once high, every output is held until out_ready is seen.
module unpack_sched
    import unpack_sched_pkg::*;
#(
    parameter int FP_W   = 64,
    parameter bit RENORM = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [FP_W-1:0] in_a,
    input  logic [FP_W-1:0] in_b,
    input  logic            in_db,
    input  logic            in_norm,
    output logic [FP_W-1:0] up_fp,
    output logic            up_db,
    output logic            up_normal,
    input  logic            up_e_inf,
    input  logic            up_e_z,
    input  logic            up_s,
    input  logic            up_fz,
    input  logic [10:0]     up_e,
    input  logic [5:0]      up_lz,
    input  logic [52:0]     up_f,
    input  logic [51:0]     up_h,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            a_s,
    output logic            b_s,
    output logic [10:0]     a_e,
    output logic [10:0]     b_e,
    output logic [52:0]     a_f,
    output logic [52:0]     b_f,
    output logic [5:0]      a_lz,
    output logic [5:0]      b_lz,
    output logic [51:0]     a_h,
    output logic [51:0]     b_h,
    output logic            a_fz,
    output logic            b_fz,
    output logic            a_ez,
    output logic            b_ez,
    output logic            a_einf,
    output logic            b_einf,
    output logic            out_db,
    output logic [2:0]      dbg_state
`ifdef UNPACK_SCHED_CLASSIFY_EN
    ,
    output logic [3:0]      a_cls,
    output logic [3:0]      b_cls,
    output logic            out_special
`endif
);

    sched_state_t    state;
    logic [FP_W-1:0] op_a;
    logic [FP_W-1:0] op_b;
    logic            db_q;
    logic            norm_q;
    logic            accept;
    logic            renorm_req;
    logic            load_a;
    logic            load_b;
    unpacked_t       up_res;
    unpacked_t       a_q;
    unpacked_t       b_q;

    assign in_ready  = (state == IDLE) && !rst;
    assign accept    = in_valid && in_ready;
    assign dbg_state = state;

    // Fields in struct order: s, e, f, lz, h, fz, ez, einf.
    assign up_res = {up_s, up_e, up_f, up_lz, up_h, up_fz, up_e_z, up_e_inf};

    // A first-pass result that is subnormal earns a second, normalising pass.
    assign renorm_req = RENORM && norm_q && up_e_z && !up_fz;

    assign load_a = (state == A0) || (state == A1);
    assign load_b = (state == B0) || (state == B1);

    // Drive the unpacker from the latched operand selected by the current pass.
    always_comb begin
        up_fp     = '0;
        up_normal = 1'b0;
        up_db     = db_q;
        case (state)
            A0: up_fp = fmt_operand(op_a, db_q);
            A1: begin
                up_fp     = fmt_operand(op_a, db_q);
                up_normal = 1'b1;
            end
            B0: up_fp = fmt_operand(op_b, db_q);
            B1: begin
                up_fp     = fmt_operand(op_b, db_q);
                up_normal = 1'b1;
            end
            default: begin
                up_fp     = '0;
                up_normal = 1'b0;
            end
        endcase
    end

    // Pass sequencing, operand latching and the output-valid flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            op_a      <= '0;
            op_b      <= '0;
            db_q      <= 1'b0;
            norm_q    <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_a   <= in_a;
                        op_b   <= in_b;
                        db_q   <= in_db;
                        norm_q <= in_norm;
                        state  <= A0;
                    end
                end
                A0: state <= renorm_req ? A1 : B0;
                A1: state <= B0;
                B0: begin
                    if (renorm_req) begin
                        state <= B1;
                    end else begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                B1: begin
                    state     <= DONE;
                    out_valid <= 1'b1;
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    unpack_capture u_cap_a (
        .clk  (clk),
        .rst  (rst),
        .clr  (accept),
        .load (load_a),
        .d    (up_res),
        .q    (a_q)
    );

    unpack_capture u_cap_b (
        .clk  (clk),
        .rst  (rst),
        .clr  (accept),
        .load (load_b),
        .d    (up_res),
        .q    (b_q)
    );

    assign a_s    = a_q.s;
    assign a_e    = a_q.e;
    assign a_f    = a_q.f;
    assign a_lz   = a_q.lz;
    assign a_h    = a_q.h;
    assign a_fz   = a_q.fz;
    assign a_ez   = a_q.ez;
    assign a_einf = a_q.einf;
    assign b_s    = b_q.s;
    assign b_e    = b_q.e;
    assign b_f    = b_q.f;
    assign b_lz   = b_q.lz;
    assign b_h    = b_q.h;
    assign b_fz   = b_q.fz;
    assign b_ez   = b_q.ez;
    assign b_einf = b_q.einf;
    assign out_db = db_q;

`ifdef UNPACK_SCHED_CLASSIFY_EN
    // Class is taken from the first pass only, so "sub" survives renormalisation.
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            a_cls <= '0;
            b_cls <= '0;
        end else if (state == A0) begin
            a_cls <= classify(up_e_inf, up_fz, up_e_z);
        end else if (state == B0) begin
            b_cls <= classify(up_e_inf, up_fz, up_e_z);
        end
    end

    assign out_special = (|a_cls[CLS_NAN:CLS_INF]) || (|b_cls[CLS_NAN:CLS_INF]);
`endif

endmodule
